// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared constants and types for the register file
package regfile_pkg;

   localparam int REG_WIDTH  = 64;
   localparam int REG_DEPTH  = 32;
   localparam int REG_ADDR_W = 5;

   typedef logic [REG_WIDTH-1:0]  reg_word_t;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - write port and two read ports of the register file
// master drives requests and write data; slave is the register file itself.
interface register_file_if
   import regfile_pkg::*;
#(
   parameter int WIDTH = REG_WIDTH,
   parameter int DEPTH = REG_DEPTH
);
   localparam int AW = $clog2(DEPTH);

   logic             we;
   logic [AW-1:0]    wa;
   logic [WIDTH-1:0] wd;
   logic             re0;
   logic [AW-1:0]    ra0;
   logic [WIDTH-1:0] rd0;
   logic             rv0;
   logic             re1;
   logic [AW-1:0]    ra1;
   logic [WIDTH-1:0] rd1;
   logic             rv1;

   modport master (
      output we, wa, wd, re0, ra0, re1, ra1,
      input  rd0, rv0, rd1, rv1
   );

   modport slave (
      input  we, wa, wd, re0, ra0, re1, ra1,
      output rd0, rv0, rd1, rv1
   );

endinterface

// File: rtl/register_file_read_port.sv
// rtl/register_file_read_port.sv - one registered read port with write bypass
// Output data only updates on a request, so rd holds while re is low.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int WIDTH   = REG_WIDTH,
   parameter int DEPTH   = REG_DEPTH,
   parameter bit ZERO_R0 = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DEPTH-1:0][WIDTH-1:0]   i_mem,
   input  logic                          i_we,
   input  logic [$clog2(DEPTH)-1:0]      i_wa,
   input  logic [WIDTH-1:0]              i_wd,
   input  logic                          i_re,
   input  logic [$clog2(DEPTH)-1:0]      i_ra,
   output logic [WIDTH-1:0]              o_rd,
   output logic                          o_rv
);

   logic [WIDTH-1:0] w_rd_next;
   logic [WIDTH-1:0] r_rd;
   logic             r_rv;

   // Zero-entry override wins over the bypass so entry 0 never leaks write data.
   always_comb begin
      w_rd_next = i_mem[i_ra];
      if (i_we && (i_wa == i_ra))
         w_rd_next = i_wd;
      if (ZERO_R0 && (i_ra == '0))
         w_rd_next = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd <= '0;
         r_rv <= 1'b0;
      end else begin
         r_rv <= i_re;
         if (i_re)
            r_rd <= w_rd_next;
      end
   end

   assign o_rd = r_rd;
   assign o_rv = r_rv;

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - register file top: storage array, write decode, two read ports
// Storage clears asynchronously; entry 0 is never written when ZERO_R0 is set.
module register_file
   import regfile_pkg::*;
#(
   parameter int WIDTH   = REG_WIDTH,
   parameter int DEPTH   = REG_DEPTH,
   parameter bit ZERO_R0 = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   register_file_if.slave  bus
);

   logic [DEPTH-1:0][WIDTH-1:0] r_mem;
   logic                        w_wr_en;

   assign w_wr_en = bus.we && !(ZERO_R0 && (bus.wa == '0));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_mem <= '0;
      else if (w_wr_en)
         r_mem[bus.wa] <= bus.wd;
   end

   regfile_read_port #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .ZERO_R0 (ZERO_R0)
   ) u_rd_port0 (
      .clk   (clk),
      .rst_n (rst),
      .i_mem (r_mem),
      .i_we  (bus.we),
      .i_wa  (bus.wa),
      .i_wd  (bus.wd),
      .i_re  (bus.re0),
      .i_ra  (bus.ra0),
      .o_rd  (bus.rd0),
      .o_rv  (bus.rv0)
   );

   regfile_read_port #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .ZERO_R0 (ZERO_R0)
   ) u_rd_port1 (
      .clk   (clk),
      .rst_n (rst),
      .i_mem (r_mem),
      .i_we  (bus.we),
      .i_wa  (bus.wa),
      .i_wd  (bus.wd),
      .i_re  (bus.re1),
      .i_ra  (bus.ra1),
      .o_rd  (bus.rd1),
      .o_rv  (bus.rv1)
   );

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed and randomized checks of register_file against an array model
module tb_register_file;
   import regfile_pkg::*;

   logic clk;
   logic rst;

   register_file_if #(.WIDTH(REG_WIDTH), .DEPTH(REG_DEPTH)) bus ();

   register_file #(
      .WIDTH   (REG_WIDTH),
      .DEPTH   (REG_DEPTH),
      .ZERO_R0 (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   reg_word_t m_mem [REG_DEPTH];
   reg_word_t exp_rd0, exp_rd1;
   logic      exp_rv0, exp_rv1;
   int        n_checks = 0;
   int        n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < REG_DEPTH; i++) m_mem[i] = '0;
      exp_rd0 = '0;
      exp_rd1 = '0;
      exp_rv0 = 1'b0;
      exp_rv1 = 1'b0;
   endtask

   function automatic reg_word_t model_read(input reg_addr_t a, input logic we,
                                            input reg_addr_t wa, input reg_word_t wd);
      if (a == 0) return '0;
      if (we && wa == a) return wd;
      return m_mem[a];
   endfunction

   // Drive one cycle of stimulus, advance the model, then compare all outputs after the edge.
   task automatic cycle(input logic we, input reg_addr_t wa, input reg_word_t wd,
                        input logic re0, input reg_addr_t ra0,
                        input logic re1, input reg_addr_t ra1, input string tag);
      bus.we  = we;  bus.wa  = wa;  bus.wd  = wd;
      bus.re0 = re0; bus.ra0 = ra0;
      bus.re1 = re1; bus.ra1 = ra1;
      if (rst) begin
         if (re0) exp_rd0 = model_read(ra0, we, wa, wd);
         if (re1) exp_rd1 = model_read(ra1, we, wa, wd);
         exp_rv0 = re0;
         exp_rv1 = re1;
         if (we && wa != 0) m_mem[wa] = wd;
      end
      @(posedge clk);
      #1;
      check({tag, ".rd0"}, bus.rd0, exp_rd0);
      check({tag, ".rv0"}, {63'd0, bus.rv0}, {63'd0, exp_rv0});
      check({tag, ".rd1"}, bus.rd1, exp_rd1);
      check({tag, ".rv1"}, {63'd0, bus.rv1}, {63'd0, exp_rv1});
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic reset_pulse(input string tag);
      #1 rst = 1'b0;
      #1;
      check({tag, ".rd0"}, bus.rd0, 64'd0);
      check({tag, ".rv0"}, {63'd0, bus.rv0}, 64'd0);
      check({tag, ".rd1"}, bus.rd1, 64'd0);
      check({tag, ".rv1"}, {63'd0, bus.rv1}, 64'd0);
      model_clear();
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      bus.we = 1'b0; bus.wa = '0; bus.wd = '0;
      bus.re0 = 1'b0; bus.ra0 = '0;
      bus.re1 = 1'b0; bus.ra1 = '0;
      model_clear();
      #1 rst = 1'b0;

      for (int i = 0; i < 3; i++)
         cycle(1'b1, 5'd5, 64'd24, 1'b1, 5'd5, 1'b0, 5'd0, "rst_hold");
      rst = 1'b1;
      cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 1'b0, 5'd0, "rst_after");
      check("rst_after_const", bus.rd0, 64'd0);

      cycle(1'b1, 5'd7, 64'd24, 1'b0, 5'd0, 1'b0, 5'd0, "wr7");
      cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 1'b0, 5'd0, "rd7");
      check("rd7_const", bus.rd0, 64'd24);
      cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd7, 1'b0, 5'd0, "hold7");
      check("hold7_const", bus.rd0, 64'd24);

      cycle(1'b1, 5'd3, 64'h11, 1'b0, 5'd0, 1'b0, 5'd0, "wr3");
      cycle(1'b1, 5'd3, 64'hFFFF_0000_0000_0001, 1'b0, 5'd0, 1'b1, 5'd3, "bypass3");
      check("bypass3_const", bus.rd1, 64'hFFFF_0000_0000_0001);

      cycle(1'b1, 5'd0, 64'd99, 1'b0, 5'd0, 1'b0, 5'd0, "wr0");
      cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 1'b1, 5'd0, "rd0");
      cycle(1'b1, 5'd0, 64'd99, 1'b1, 5'd0, 1'b1, 5'd0, "bypass0");
      check("bypass0_const", bus.rd1, 64'd0);

      cycle(1'b1, 5'd1, 64'd10, 1'b0, 5'd0, 1'b0, 5'd0, "wr1");
      cycle(1'b1, 5'd2, 64'd20, 1'b0, 5'd0, 1'b0, 5'd0, "wr2");
      cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd1, 1'b1, 5'd2, "dual12");
      check("dual12_const", bus.rd0, 64'd10);
      cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd2, 1'b1, 5'd2, "dual22");
      check("dual22_const", bus.rd0, 64'd20);

      cycle(1'b1, 5'd4, 64'd55, 1'b0, 5'd0, 1'b0, 5'd0, "wr4");
      cycle(1'b1, 5'd6, 64'd66, 1'b0, 5'd0, 1'b0, 5'd0, "wr6");
      cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd4, 1'b1, 5'd6, "rd46");
      reset_pulse("mid_rst");
      cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd4, 1'b1, 5'd6, "rd46_after");

      for (int n = 0; n < 600; n++) begin
         reg_addr_t wa, ra0, ra1;
         logic [1:0] narrow;
         narrow = 2'($urandom_range(0, 3));
         wa  = (narrow == 0) ? reg_addr_t'($urandom_range(0, 3)) : reg_addr_t'($urandom_range(0, 31));
         ra0 = (narrow == 0) ? reg_addr_t'($urandom_range(0, 3)) : reg_addr_t'($urandom_range(0, 31));
         ra1 = (narrow == 1) ? ra0 : reg_addr_t'($urandom_range(0, 31));
         if ($urandom_range(0, 99) == 0)
            reset_pulse("rand_rst");
         cycle(1'($urandom_range(0, 1)), wa, {$urandom, $urandom},
               1'($urandom_range(0, 1)), ra0, 1'($urandom_range(0, 1)), ra1, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/register_file.md
# register_file

- Multi-entry 64-bit register file: one synchronous write port, two independent registered read ports.
- Read-request handshake on each read port; write-to-read bypass on the same clock edge.
- Sits between the datapath's operand-fetch stage and writeback, in place of loose 64-bit registers.
- Every entry and output clears to zero on reset.

## Interface

- WIDTH, 64: data width in bits.
- DEPTH, 32: number of entries; must be a power of two, at least 2.
- ZERO_R0, 1: when 1, entry 0 always reads 0 and writes to it are dropped.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- we  input  1  write enable.
- wa  input  log2(DEPTH)  write address.
- wd  input  WIDTH  write data.
- re0  input  1  read request, port 0.
- ra0  input  log2(DEPTH)  read address, port 0.
- rd0  output  WIDTH  read data, port 0.
- rv0  output  1  read valid, port 0.
- re1, ra1, rd1, rv1: same as port 0, for port 1.

## Operation

- **Storage:** DEPTH entries of WIDTH bits.
- **Write:** on a rising edge with we=1, entry[wa] ← wd.
  - If ZERO_R0=1 and wa=0, the write is discarded.
- **Read (per port, independent):**
  - On a rising edge with reN=1: rdN ← entry[raN], rvN ← 1.
  - On a rising edge with reN=0: rvN ← 0 and rdN holds its previous value.
- **Bypass:** if reN=1, we=1 and raN=wa on the same edge, rdN ← wd (new data, not old).
  - Exception: with ZERO_R0=1 and address 0, rdN ← 0.
- **Entry 0:** with ZERO_R0=1, any read of address 0 returns 0, whatever was written.
- **Shared addresses:** both ports may read the same address on the same edge; both get identical data.
- **Arithmetic:** none. Addresses are used exactly as given; log2(DEPTH) bits cover every entry, so there is no out-of-range case.
- **Stateless ports:** no state machine; each port is a one-stage registered pipeline with its own valid bit.

## Timing

- **Reset:**
  - rst falling to 0 immediately clears all entries, rd0, rd1, rv0 and rv1, with no clock needed.
  - While rst=0: writes are ignored, reads are ignored, all outputs stay 0.
- **Reset release:**
  - Release is synchronous to clk: the first edge with rst=1 is the first edge that samples we/reN.
  - Reset asserted mid-operation discards any write or read sampled on that edge.
- **Write latency:**
  - Data written at edge T is readable by a request sampled at edge T, through the bypass.
  - From edge T+1 onward it is read from storage.
- **Read latency:** one cycle. A request sampled at edge T gives rdN/rvN valid from just after T until edge T+1.
- **Back-to-back reads:** allowed every cycle on both ports. Throughput is one read per port per cycle.
- **Ready:** there is no ready/backpressure; the file always accepts.
- **Output hold:** rdN is stable whenever reN=0. Downstream logic qualifies data with rvN.

## Structure

- **Shared package regfile_pkg:**
  - constants REG_WIDTH=64, REG_DEPTH=32, REG_ADDR_W=5.
  - typedef reg_word_t, a WIDTH-bit vector.
  - typedef reg_addr_t, a REG_ADDR_W-bit vector.
- **Sub-module regfile_read_port**, instantiated twice. It contains:
  - the read mux;
  - the bypass compare;
  - the zero-entry override;
  - the rdN/rvN output registers with async active-low clear.
- **Top level** owns the storage array and write decode.

## Test plan

- **Reset:** hold rst=0 for 3 cycles with we=1, wa=5, wd=24, re0=1, ra0=5.
  - Required: rd0=0 and rv0=0 throughout.
  - After release, reading address 5 returns 0.
- **Write then read:** write wd=24 to wa=7 at edge T; re0=1, ra0=7 at edge T+1.
  - Required: rd0=24, rv0=1 after T+1.
  - With re0=0 at T+2: rv0=0 and rd0 holds 24.
- **Bypass:** entry 3 holds 0x11. On one edge: we=1, wa=3, wd=0xFFFF_0000_0000_0001, re1=1, ra1=3.
  - Required: rd1=0xFFFF_0000_0000_0001 after that edge.
- **Zero entry:** with ZERO_R0=1, write wd=99 to wa=0, then read address 0 on both ports.
  - Required: rd0=rd1=0 and rv0=rv1=1.
  - Same write+read on one edge also returns 0.
- **Dual port:** entries 1=10 and 2=20. Read ra0=1, ra1=2 together; then ra0=ra1=2.
  - Required: rd0=10, rd1=20 after the first edge; then rd0=rd1=20.
- **Reset mid-operation:** after entries 4=55 and 6=66 are written, pull rst low between edges.
  - Required: rd0, rd1, rv0 and rv1 go to 0 at once, with no clock.
  - After release, reads of 4 and 6 return 0.
